// File: rtl/mem_port_responder_pkg.sv
// Shared message types, responder state encodings and response header for
// the nibble-serial memory port responder.
package mem_port_responder_pkg;

    localparam int MSG_TYPE_BITS = 2;
    localparam int CNT_BITS      = 8;

    typedef enum logic [MSG_TYPE_BITS-1:0] {
        MSG_NOP   = 2'd0,
        MSG_READ  = 2'd1,
        MSG_WRITE = 2'd2,
        MSG_RSVD  = 2'd3
    } msg_type_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_WDATA     = 3'd2,
        ST_MEM       = 3'd3,
        ST_GAP       = 3'd4,
        ST_RESP_HDR  = 3'd5,
        ST_RESP_DATA = 3'd6
    } resp_state_e;

    localparam logic [3:0] RESP_HEADER = 4'b1001;

    // Only READ and WRITE headers start a transaction; NOP/RSVD are dropped.
    function automatic logic is_access(input msg_type_e msg_type);
        return (msg_type == MSG_READ) || (msg_type == MSG_WRITE);
    endfunction

endpackage

// File: rtl/mem_port_responder_nibble_shift_reg.sv
// Nibble-wide shift register: LSB nibble first shift-in from the top, the
// current low nibble is the next one to shift out. Optional parallel load.
module mem_port_responder_nibble_shift_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             shift_en,
    input  logic [3:0]       nibble_in,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_r;

    generate
        if (WIDTH == 4) begin : g_single
            // Single-nibble register: a shift simply replaces the content.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    value_r <= '0;
                end else if (load) begin
                    value_r <= load_value;
                end else if (shift_en) begin
                    value_r <= nibble_in;
                end
            end
        end else begin : g_multi
            // New nibble enters at the top so the first one ends up at bits [3:0].
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    value_r <= '0;
                end else if (load) begin
                    value_r <= load_value;
                end else if (shift_en) begin
                    value_r <= {nibble_in, value_r[WIDTH-1:4]};
                end
            end
        end
    endgenerate

    assign value = value_r;

endmodule

// File: rtl/mem_port_responder.sv
// Memory-side responder: deserializes nibble requests from the CPU, runs a
// req/ack access on the parallel memory port and serializes read data back.
module mem_port_responder
    import mem_port_responder_pkg::*;
#(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 16,
    parameter int RX_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           tx_pins,
    output logic [3:0]           rx_pins,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [CNT_BITS-1:0] ADDR_LAST = CNT_BITS'(ADDR_BITS / 4 - 1);
    localparam logic [CNT_BITS-1:0] DATA_LAST = CNT_BITS'(DATA_BITS / 4 - 1);
    localparam logic [CNT_BITS-1:0] GAP_LAST  = CNT_BITS'(RX_LATENCY - 1);

    resp_state_e          state_r;
    msg_type_e            type_r;
    logic [CNT_BITS-1:0]  cnt_r;
    logic [3:0]           rx_r;
    logic                 mem_req_r;
    logic                 mem_we_r;
    logic                 overrun_r;

    logic                 start_s;
    logic                 addr_shift_s;
    logic                 wdata_shift_s;
    logic                 rdata_load_s;
    logic                 rdata_shift_s;
    logic                 late_state_s;
    logic [DATA_BITS-1:0] rdata_word_s;
    logic                 rdata_unused_s;

    assign start_s = tx_pins[3];

    // Shift/load enables for the three nibble registers, decoded from state.
    always_comb begin
        addr_shift_s  = 1'b0;
        wdata_shift_s = 1'b0;
        rdata_load_s  = 1'b0;
        rdata_shift_s = 1'b0;
        late_state_s  = 1'b0;
        case (state_r)
            ST_ADDR:  addr_shift_s  = 1'b1;
            ST_WDATA: wdata_shift_s = 1'b1;
            ST_MEM: begin
                rdata_load_s = mem_ack && (type_r == MSG_READ);
                late_state_s = 1'b1;
            end
            ST_GAP:   late_state_s  = 1'b1;
            ST_RESP_HDR, ST_RESP_DATA: begin
                rdata_shift_s = 1'b1;
                late_state_s  = 1'b1;
            end
            default: begin
                addr_shift_s  = 1'b0;
                late_state_s  = 1'b0;
            end
        endcase
    end

    mem_port_responder_nibble_shift_reg #(.WIDTH(ADDR_BITS)) u_addr_sr (
        .clk        (clk),
        .reset      (reset),
        .load       (1'b0),
        .load_value ('0),
        .shift_en   (addr_shift_s),
        .nibble_in  (tx_pins),
        .value      (mem_addr)
    );

    mem_port_responder_nibble_shift_reg #(.WIDTH(DATA_BITS)) u_wdata_sr (
        .clk        (clk),
        .reset      (reset),
        .load       (1'b0),
        .load_value ('0),
        .shift_en   (wdata_shift_s),
        .nibble_in  (tx_pins),
        .value      (mem_wdata)
    );

    mem_port_responder_nibble_shift_reg #(.WIDTH(DATA_BITS)) u_rdata_sr (
        .clk        (clk),
        .reset      (reset),
        .load       (rdata_load_s),
        .load_value (mem_rdata),
        .shift_en   (rdata_shift_s),
        .nibble_in  (4'd0),
        .value      (rdata_word_s)
    );

    // Only the low nibble of the read register feeds the pins.
    assign rdata_unused_s = ^rdata_word_s;

    // Transaction sequencer; rx_pins/mem_req/mem_we are set on the transition
    // so they are already valid in the first cycle of the new state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            type_r    <= MSG_NOP;
            cnt_r     <= '0;
            rx_r      <= 4'd0;
            mem_req_r <= 1'b0;
            mem_we_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s && is_access(msg_type_e'(tx_pins[1:0]))) begin
                        type_r  <= msg_type_e'(tx_pins[1:0]);
                        cnt_r   <= '0;
                        state_r <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (cnt_r == ADDR_LAST) begin
                        cnt_r <= '0;
                        if (type_r == MSG_WRITE) begin
                            state_r <= ST_WDATA;
                        end else begin
                            state_r   <= ST_MEM;
                            mem_req_r <= 1'b1;
                            mem_we_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_BITS'(1);
                    end
                end
                ST_WDATA: begin
                    if (cnt_r == DATA_LAST) begin
                        cnt_r     <= '0;
                        state_r   <= ST_MEM;
                        mem_req_r <= 1'b1;
                        mem_we_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_BITS'(1);
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        mem_req_r <= 1'b0;
                        cnt_r     <= '0;
                        if (type_r == MSG_WRITE) begin
                            state_r <= ST_IDLE;
                        end else if (RX_LATENCY == 0) begin
                            state_r <= ST_RESP_HDR;
                            rx_r    <= RESP_HEADER;
                        end else begin
                            state_r <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        state_r <= ST_RESP_HDR;
                        rx_r    <= RESP_HEADER;
                    end else begin
                        cnt_r <= cnt_r + CNT_BITS'(1);
                    end
                end
                ST_RESP_HDR: begin
                    rx_r    <= rdata_word_s[3:0];
                    cnt_r   <= '0;
                    state_r <= ST_RESP_DATA;
                end
                ST_RESP_DATA: begin
                    if (cnt_r == DATA_LAST) begin
                        rx_r    <= 4'd0;
                        state_r <= ST_IDLE;
                    end else begin
                        rx_r  <= rdata_word_s[3:0];
                        cnt_r <= cnt_r + CNT_BITS'(1);
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    rx_r      <= 4'd0;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // A start nibble after the request phase is dropped but remembered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (start_s && late_state_s) begin
            overrun_r <= 1'b1;
        end
    end

    assign rx_pins = rx_r;
    assign mem_req = mem_req_r;
    assign mem_we  = mem_we_r;
    assign busy    = (state_r != ST_IDLE);
    assign overrun = overrun_r;

endmodule

// File: tb/tb_mem_port_responder.sv
// Self-checking bench for mem_port_responder: directed table, randomized
// transactions against a transaction-level memory model, overrun and reset.
module tb_mem_port_responder;

    localparam int AB  = 16;
    localparam int DB  = 16;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [3:0]    tx_pins = 4'd0;
    logic [3:0]    rx_pins;
    logic          mem_req;
    logic          mem_we;
    logic [AB-1:0] mem_addr;
    logic [DB-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DB-1:0] mem_rdata = '0;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_mem  [logic [15:0]];
    logic [15:0] phys_mem [logic [15:0]];
    logic [15:0] last_addr;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          wt;
        logic [15:0] exp_rd;
    } txn_vec_t;

    typedef struct {
        logic [3:0] tx;
        logic       ack;
    } idle_vec_t;

    mem_port_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .RX_LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_pins   (tx_pins),
        .rx_pins   (rx_pins),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one full transaction and check every cycle of it.
    task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                           input int wt, input logic [15:0] exp_rd,
                           input bit gap_ov, input bit abort_resp);
        tx_pins = wr ? 4'b1010 : 4'b1001;
        step();
        chk("hdr_busy", busy, 1);
        for (int i = 0; i < AB / 4; i++) begin
            tx_pins = addr[4*i +: 4];
            if (i == AB / 4 - 1) chk("req_early", mem_req, 0);
            step();
        end
        if (wr) begin
            for (int i = 0; i < DB / 4; i++) begin
                tx_pins = data[4*i +: 4];
                chk("req_in_wdata", mem_req, 0);
                step();
            end
        end
        tx_pins = 4'($urandom_range(0, 7));
        chk("req_rise", mem_req, 1);
        chk("mem_addr", mem_addr, addr);
        chk("mem_we", mem_we, wr);
        if (wr) chk("mem_wdata", mem_wdata, data);
        for (int n = 0; n <= wt; n++) begin
            chk("req_held", mem_req, 1);
            chk("rx_idle_mem", rx_pins, 0);
            mem_ack = (n == wt);
            if (n == wt) begin
                if (wr) phys_mem[mem_addr] = mem_wdata;
                mem_rdata = phys_mem.exists(mem_addr) ? phys_mem[mem_addr] : dflt(mem_addr);
            end else begin
                mem_rdata = 16'($urandom);
            end
            step();
        end
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
        chk("req_drop", mem_req, 0);
        if (wr) begin
            chk("wr_done_busy", busy, 0);
            chk("wr_rx", rx_pins, 0);
            return;
        end
        for (int g = 0; g < LAT; g++) begin
            chk("gap_rx", rx_pins, 0);
            chk("gap_busy", busy, 1);
            tx_pins = (gap_ov && g == 0) ? 4'b1001 : 4'($urandom_range(0, 7));
            step();
        end
        tx_pins = 4'($urandom_range(0, 7));
        chk("resp_hdr", rx_pins, 4'b1001);
        step();
        for (int i = 0; i < DB / 4; i++) begin
            if (abort_resp && i == 2) begin
                reset = 1'b1;
                #1;
                chk("abort_rx", rx_pins, 0);
                chk("abort_req", mem_req, 0);
                chk("abort_busy", busy, 0);
                chk("abort_overrun", overrun, 0);
                chk("abort_addr", mem_addr, 0);
                step();
                reset = 1'b0;
                return;
            end
            chk("resp_nib", rx_pins, exp_rd[4*i +: 4]);
            step();
        end
        chk("resp_end_rx", rx_pins, 0);
        chk("resp_end_busy", busy, 0);
    endtask

    task automatic model_txn(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                             input int wt, input bit gap_ov, input bit abort_resp);
        logic [15:0] exp;
        if (wr) exp_mem[addr] = data;
        exp = exp_mem.exists(addr) ? exp_mem[addr] : dflt(addr);
        run_txn(wr, addr, data, wt, exp, gap_ov, abort_resp);
        last_addr = addr;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_vec_t    tbl [6];
        idle_vec_t   idle_tbl [6];
        logic [15:0] pool [4];
        bit          r_wr;
        logic [15:0] r_addr;
        logic [15:0] r_data;
        int          r_wt;

        tbl[0] = '{wr: 1'b0, addr: 16'h1234, data: 16'h0000, wt: 0, exp_rd: 16'hBEEF};
        tbl[1] = '{wr: 1'b1, addr: 16'h00A5, data: 16'hC3D2, wt: 3, exp_rd: 16'h0000};
        tbl[2] = '{wr: 1'b0, addr: 16'h00A5, data: 16'h0000, wt: 2, exp_rd: 16'hC3D2};
        tbl[3] = '{wr: 1'b0, addr: 16'h0777, data: 16'h0000, wt: 1, exp_rd: 16'h5D2D};
        tbl[4] = '{wr: 1'b1, addr: 16'hFFFF, data: 16'h0001, wt: 0, exp_rd: 16'h0000};
        tbl[5] = '{wr: 1'b0, addr: 16'hFFFF, data: 16'h0000, wt: 0, exp_rd: 16'h0001};

        idle_tbl[0] = '{tx: 4'b1000, ack: 1'b0};
        idle_tbl[1] = '{tx: 4'b1011, ack: 1'b1};
        idle_tbl[2] = '{tx: 4'b0001, ack: 1'b0};
        idle_tbl[3] = '{tx: 4'b0010, ack: 1'b1};
        idle_tbl[4] = '{tx: 4'b1100, ack: 1'b0};
        idle_tbl[5] = '{tx: 4'b1111, ack: 1'b1};

        pool[0] = 16'h0010;
        pool[1] = 16'h0020;
        pool[2] = 16'hFFFF;
        pool[3] = 16'h8001;

        phys_mem[16'h1234] = 16'hBEEF;
        exp_mem[16'h1234]  = 16'hBEEF;

        #2;
        reset = 1'b1;
        #1;
        chk("rst_rx", rx_pins, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        step();
        step();
        reset = 1'b0;

        // Directed table, back-to-back with no idle cycles in between.
        foreach (tbl[k]) begin
            run_txn(tbl[k].wr, tbl[k].addr, tbl[k].data, tbl[k].wt, tbl[k].exp_rd, 1'b0, 1'b0);
            if (tbl[k].wr) exp_mem[tbl[k].addr] = tbl[k].data;
            last_addr = tbl[k].addr;
        end
        chk("b2b_overrun", overrun, 0);

        // Headers that must not start anything; stray acks are ignored.
        foreach (idle_tbl[k]) begin
            tx_pins = idle_tbl[k].tx;
            mem_ack = idle_tbl[k].ack;
            step();
            chk("idle_busy", busy, 0);
            chk("idle_req", mem_req, 0);
            chk("idle_rx", rx_pins, 0);
            chk("idle_addr_hold", mem_addr, last_addr);
        end
        mem_ack = 1'b0;
        tx_pins = 4'd0;
        step();

        for (int k = 0; k < 24; k++) begin
            r_wr   = 1'($urandom_range(0, 1));
            r_addr = pool[$urandom_range(0, 3)];
            r_data = 16'($urandom);
            r_wt   = $urandom_range(0, 3);
            model_txn(r_wr, r_addr, r_data, r_wt, 1'b0, 1'b0);
        end
        chk("rand_overrun", overrun, 0);

        model_txn(1'b0, 16'h0010, 16'h0000, 1, 1'b1, 1'b0);
        chk("overrun_set", overrun, 1);
        model_txn(1'b1, 16'h4242, 16'h9A9A, 0, 1'b0, 1'b0);
        model_txn(1'b0, 16'h4242, 16'h0000, 2, 1'b0, 1'b0);
        chk("overrun_sticky", overrun, 1);

        model_txn(1'b0, 16'h00A5, 16'h0000, 0, 1'b0, 1'b1);
        model_txn(1'b0, 16'h1234, 16'h0000, 1, 1'b0, 1'b0);
        chk("post_reset_overrun", overrun, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
